mpu_det_sequencer: RTL and testbench

Computes the determinant of an NxN signed 8-bit matrix (N = 1..5) using a single shared 8x8 signed multiplier.
- Sequences a Leibniz expansion: enumerates all N! permutations with Heap's algorithm, forms each signed product, and accumulates.
- Replaces the wide parallel determinant datapath in the MPU operation path: fewer multipliers, multi-cycle latency.
- Driven by the MPU instruction decoder through a start/done handshake.

---
 rtl/mpu_det_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mpu_det_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_det_sequencer.sv
// Determinant of an NxN signed 8-bit matrix (N = 1..MAX_N) by Leibniz expansion.
// Permutations come from an iterative Heap's algorithm. One shared 8x8 signed
// multiplier forms each permutation product, one element per cycle, and all
// arithmetic wraps modulo 256.
module mpu_det_sequencer #(
  parameter int unsigned MAX_N = 5
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [7:0]                 size_i,
  input  logic [8*MAX_N*MAX_N-1:0]   matrix_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [7:0]                 result_o
);

  localparam int unsigned MW = 8 * MAX_N * MAX_N;
  localparam int unsigned IW = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROD,
    S_ACC,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   mat_q, mat_d;
  logic [IW-1:0]   n_q, n_d;
  logic [IW-1:0]   perm_q [MAX_N];
  logic [IW-1:0]   perm_d [MAX_N];
  logic [IW-1:0]   c_q [MAX_N];
  logic [IW-1:0]   c_d [MAX_N];
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   k_q, k_d;
  logic            sign_q, sign_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      prod_q, prod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [7:0]      result_q, result_d;

  logic               size_ok_c;
  logic [7:0]         elem_c;
  logic signed [15:0] mul_c;

  // Sizes 1..MAX_N only; negative sizes look large when compared unsigned.
  assign size_ok_c = (size_i != 8'd0) && (size_i <= 8'(MAX_N));

  // Element M[k][perm[k]] feeding the multiplier this cycle.
  assign elem_c = mat_q[8 * (int'(perm_q[k_q]) + int'(MAX_N) * int'(k_q)) +: 8];

  // Shared signed multiplier; only the low byte is kept.
  assign mul_c = $signed(prod_q) * $signed(elem_c);

  // Next-state and datapath update for the Leibniz/Heap sequencer.
  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    n_d      = n_q;
    perm_d   = perm_q;
    c_d      = c_q;
    i_d      = i_q;
    k_d      = k_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (size_ok_c) begin
            mat_d  = matrix_i;
            n_d    = size_i[IW-1:0];
            for (int j = 0; j < int'(MAX_N); j++) begin
              perm_d[j] = IW'(j);
              c_d[j]    = '0;
            end
            i_d     = IW'(1);
            k_d     = '0;
            sign_d  = 1'b0;
            acc_d   = 8'd0;
            prod_d  = 8'd0;
            busy_d  = 1'b1;
            state_d = S_PROD;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_PROD: begin
        prod_d = (k_q == '0) ? elem_c : mul_c[7:0];
        k_d    = k_q + IW'(1);
        if (k_q == n_q - IW'(1)) begin
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        acc_d   = sign_q ? (acc_q - prod_q) : (acc_q + prod_q);
        state_d = S_NEXT;
      end

      S_NEXT: begin
        if (i_q >= n_q) begin
          state_d = S_FINISH;
        end else if (c_q[i_q] < i_q) begin
          if (!i_q[0]) begin
            perm_d[0]   = perm_q[i_q];
            perm_d[i_q] = perm_q[0];
          end else begin
            perm_d[c_q[i_q]] = perm_q[i_q];
            perm_d[i_q]      = perm_q[c_q[i_q]];
          end
          c_d[i_q] = c_q[i_q] + IW'(1);
          i_d      = IW'(1);
          sign_d   = ~sign_q;
          k_d      = '0;
          state_d  = S_PROD;
        end else begin
          c_d[i_q] = '0;
          i_d      = i_q + IW'(1);
        end
      end

      S_FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      mat_q    <= '0;
      n_q      <= '0;
      for (int j = 0; j < int'(MAX_N); j++) begin
        perm_q[j] <= '0;
        c_q[j]    <= '0;
      end
      i_q      <= '0;
      k_q      <= '0;
      sign_q   <= 1'b0;
      acc_q    <= 8'd0;
      prod_q   <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      n_q      <= n_d;
      for (int j = 0; j < int'(MAX_N); j++) begin
        perm_q[j] <= perm_d[j];
        c_q[j]    <= c_d[j];
      end
      i_q      <= i_d;
      k_q      <= k_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign error_o  = error_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mpu_det_sequencer.sv
// Bench for mpu_det_sequencer: directed cases plus random matrices checked
// against a brute-force permutation-sum determinant model.
module tb_mpu_det_sequencer;

  typedef logic [199:0] mat_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] size;
  mat_t       matrix;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mpu_det_sequencer #(.MAX_N(5)) dut (
    .clock_i  (clock),
    .reset_i  (reset),
    .start_i  (start),
    .size_i   (size),
    .matrix_i (matrix),
    .busy_o   (busy),
    .done_o   (done),
    .error_o  (error),
    .result_o (result)
  );

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mat_t set_el(input mat_t m, input int r, input int c, input int v);
    mat_t t;
    t = m;
    t[8*(c+5*r) +: 8] = 8'(v);
    return t;
  endfunction

  // Determinant as the signed sum over all permutations (inversion parity), mod 256.
  function automatic logic [7:0] ref_det(input mat_t m, input int n);
    longint acc;
    longint prod;
    int     tot;
    int     t;
    int     inv;
    bit     ok;
    int     p [5];
    acc = 0;
    tot = 1;
    for (int j = 0; j < n; j++) tot = tot * n;
    for (int x = 0; x < tot; x++) begin
      t = x;
      for (int r = 0; r < n; r++) begin
        p[r] = t % n;
        t    = t / n;
      end
      ok  = 1'b1;
      inv = 0;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++) begin
          if (p[a] == p[b]) ok = 1'b0;
          if (p[a] > p[b]) inv++;
        end
      if (ok) begin
        prod = 1;
        for (int r = 0; r < n; r++)
          prod = prod * longint'($signed(m[8*(p[r]+5*r) +: 8]));
        acc = (inv % 2 == 0) ? acc + prod : acc - prod;
      end
    end
    return acc[7:0];
  endfunction

  // Pulse start, then watch outputs for up to limit cycles; optionally inject a second start.
  task automatic run_op(input logic [7:0] sz, input mat_t m, input int limit,
                        input int inj_cyc, input logic [7:0] inj_sz, input mat_t inj_m,
                        output int lat, output int ndone, output int nerr, output int nbusy);
    size   = sz;
    matrix = m;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    lat    = 0;
    ndone  = 0;
    nerr   = 0;
    nbusy  = 0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (error) nerr++;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = cyc;
      end
      if (ndone > 0 && cyc >= lat + 2) break;
      if (cyc == inj_cyc) begin
        size   = inj_sz;
        matrix = inj_m;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic do_valid(input string tag, input logic [7:0] sz, input mat_t m,
                          input logic [7:0] exp, output int lat);
    int nd, ne, nb;
    run_op(sz, m, 2000, 0, 8'd0, '0, lat, nd, ne, nb);
    chk({tag, "_res"},  32'(result), 32'(exp));
    chk({tag, "_done"}, 32'(nd), 32'd1);
    chk({tag, "_err"},  32'(ne), 32'd0);
    chk({tag, "_busy"}, 32'(nb), 32'(lat - 1));
  endtask

  task automatic do_invalid(input string tag, input logic [7:0] sz);
    int lat, nd, ne, nb;
    logic [7:0] prev;
    prev = result;
    run_op(sz, '1, 12, 0, 8'd0, '0, lat, nd, ne, nb);
    chk({tag, "_err"},  32'(ne), 32'd1);
    chk({tag, "_done"}, 32'(nd), 32'd0);
    chk({tag, "_busy"}, 32'(nb), 32'd0);
    chk({tag, "_keep"}, 32'(result), 32'(prev));
  endtask

  initial begin
    mat_t m;
    mat_t m2;
    int   lat, lat1, lat2, nd, ne, nb, sz;
    int   lat_by_n [6];
    logic [7:0] exp;

    for (int j = 0; j < 6; j++) lat_by_n[j] = -1;
    reset  = 1'b1;
    start  = 1'b0;
    size   = 8'd0;
    matrix = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_error",  32'(error),  32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 2x2 basic
    m = '0;
    m = set_el(m, 0, 0, 3); m = set_el(m, 0, 1, 4);
    m = set_el(m, 1, 0, 2); m = set_el(m, 1, 1, 5);
    do_valid("det2", 8'd2, m, 8'd7, lat);

    // diag(2,2,2)
    m = '0;
    for (int j = 0; j < 3; j++) m = set_el(m, j, j, 2);
    do_valid("diag3", 8'd3, m, 8'd8, lat);

    // 5x5 identity, latency bound and repeatability
    m = '0;
    for (int j = 0; j < 5; j++) m = set_el(m, j, j, 1);
    do_valid("id5a", 8'd5, m, 8'd1, lat1);
    chk("lat5_bound", 32'(lat1 > 0 && lat1 <= 1000), 32'd1);
    do_valid("id5b", 8'd5, m, 8'd1, lat2);
    chk("lat5_repeat", 32'(lat2), 32'(lat1));

    // 4x4 with rows 0 and 2 equal
    m = '0;
    for (int c = 0; c < 4; c++) begin
      m = set_el(m, 0, c, c + 1);
      m = set_el(m, 2, c, c + 1);
      m = set_el(m, 1, c, 5 + c + (c == 3 ? 1 : 0));
      m = set_el(m, 3, c, 2 * c + 2 + (c > 1 ? 1 : 0));
    end
    do_valid("dup4", 8'd4, m, 8'd0, lat);

    // single row swap of identity
    m = '0;
    m = set_el(m, 0, 1, 1); m = set_el(m, 1, 0, 1);
    for (int j = 2; j < 5; j++) m = set_el(m, j, j, 1);
    do_valid("swap5", 8'd5, m, 8'hFF, lat);

    // modulo-256 wrap
    m = '0;
    m = set_el(m, 0, 0, 16); m = set_el(m, 1, 1, 16);
    do_valid("wrap0", 8'd2, m, 8'd0, lat);
    m = '0;
    m = set_el(m, 0, 0, 12); m = set_el(m, 1, 1, 11);
    do_valid("wrap84", 8'd2, m, 8'h84, lat);

    // invalid sizes
    do_invalid("size0",   8'd0);
    do_invalid("size6",   8'd6);
    do_invalid("sizeneg", 8'hFB);

    // start while busy is ignored and operand changes do not leak in
    m = '0;
    m = set_el(m, 0, 0, 3); m = set_el(m, 0, 1, 4);
    m = set_el(m, 1, 0, 2); m = set_el(m, 1, 1, 5);
    m2 = '1;
    run_op(8'd2, m, 2000, 3, 8'd3, m2, lat, nd, ne, nb);
    chk("busy_start_res",  32'(result), 32'd7);
    chk("busy_start_done", 32'(nd), 32'd1);
    chk("busy_start_err",  32'(ne), 32'd0);

    // random matrices, including garbage outside the active NxN corner
    for (int t = 0; t < 30; t++) begin
      for (int b = 0; b < 25; b++) m[8*b +: 8] = 8'($urandom);
      sz  = int'($urandom_range(1, 5));
      exp = ref_det(m, sz);
      do_valid($sformatf("rnd%0d_n%0d", t, sz), 8'(sz), m, exp, lat);
      if (lat_by_n[sz] < 0) lat_by_n[sz] = lat;
      else chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(lat_by_n[sz]));
    end

    // reset mid-computation aborts with no done
    m = '0;
    for (int j = 0; j < 5; j++) m = set_el(m, j, j, 1);
    size   = 8'd5;
    matrix = m;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    repeat (299) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    chk("midrst_error",  32'(error),  32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    reset = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("midrst_nodone", 32'(nd), 32'd0);
    m = '0;
    m = set_el(m, 0, 0, -7);
    for (int b = 1; b < 25; b++) m[8*b +: 8] = 8'($urandom);
    do_valid("n1_neg7", 8'd1, m, 8'hF9, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
